// File: rtl/video_arith_arb_if.sv
// Bundle between the arithmetic arbiter, its requesters and the shared
// multiplier/divider units.
interface video_arith_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_op;
    logic [NREQ*24-1:0] req_a;
    logic [NREQ*12-1:0] req_b;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [23:0]        res;
    logic               busy;

    logic               mul_start;
    logic               mul_run;
    logic [11:0]        mul_arg1;
    logic [11:0]        mul_arg2;
    logic [23:0]        mul_res;

    logic               div_start;
    logic               div_run;
    logic [23:0]        div_num;
    logic [11:0]        div_den;
    logic [23:0]        div_res;

    modport slave (
        input  req, req_op, req_a, req_b,
        input  mul_run, mul_res, div_run, div_res,
        output done, err, res, busy,
        output mul_start, mul_arg1, mul_arg2,
        output div_start, div_num, div_den
    );

    modport master (
        output req, req_op, req_a, req_b,
        output mul_run, mul_res, div_run, div_res,
        input  done, err, res, busy,
        input  mul_start, mul_arg1, mul_arg2,
        input  div_start, div_num, div_den
    );
endinterface

// File: rtl/video_arith_arb.sv
// Round-robin sharing of one 12x12 multiplier and one 24/12 divider
// between NREQ video-path requesters, one operation in flight.
module video_arith_arb #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input logic              CLK_VIDEO,
    input logic              RESET,
    video_arith_arb_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT1,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            op_q, op_d;
    logic [23:0]     res_q, res_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [11:0]     arg1_q, arg1_d;
    logic [11:0]     arg2_q, arg2_d;
    logic [23:0]     num_q, num_d;
    logic [11:0]     den_q, den_d;

    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   idx_v;
    logic [23:0]     gnt_a;
    logic [11:0]     gnt_b;
    logic            run_sel;

    // Scan downwards so the entry closest to the pointer is written last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx_v   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_v = PW'((int'(ptr_q) + k) % NREQ);
            if (bus.req[idx_v]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_v;
            end
        end
    end

    assign gnt_a   = bus.req_a[24*gnt_idx +: 24];
    assign gnt_b   = bus.req_b[12*gnt_idx +: 12];
    assign run_sel = op_q ? bus.div_run : bus.mul_run;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        arg1_d  = arg1_q;
        arg2_d  = arg2_q;
        num_d   = num_q;
        den_d   = den_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    op_d    = bus.req_op[gnt_idx];
                    if (bus.req_op[gnt_idx]) begin
                        num_d = gnt_a;
                        den_d = gnt_b;
                    end else begin
                        arg1_d = gnt_a[11:0];
                        arg2_d = gnt_b;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_q && (den_q == 12'd0)) begin
                    res_d   = 24'hFFFFFF;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!run_sel) begin
                    res_d   = op_q ? bus.div_res : bus.mul_res;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = 24'd0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_VIDEO or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            op_q    <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            arg1_q  <= '0;
            arg2_q  <= '0;
            num_q   <= '0;
            den_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            arg1_q  <= arg1_d;
            arg2_q  <= arg2_d;
            num_q   <= num_d;
            den_q   <= den_d;
        end
    end

    assign bus.done      = (state_q == S_DONE) ? (NREQ'(1) << owner_q) : '0;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.res       = res_q;
    assign bus.err       = err_q;
    assign bus.mul_start = (state_q == S_ISSUE) && !op_q;
    assign bus.div_start = (state_q == S_ISSUE) && op_q && (den_q != 12'd0);
    assign bus.mul_arg1  = arg1_q;
    assign bus.mul_arg2  = arg2_q;
    assign bus.div_num   = num_q;
    assign bus.div_den   = den_q;
endmodule

// File: doc/video_arith_arb.md
Name: video_arith_arb

Overview:
- Shares one 12x12 multiplier (sys_umul interface) and one 24/12 divider (sys_udiv interface) between NREQ requesters in the video path, e.g. crop aspect calc and integer-scale calc.
- Arbitration is round-robin, with one operation in flight at a time.
- Sequences the start/run handshake of the units and returns each result to the owning requester with a one-cycle done strobe.
- Removes the duplicated mul/div instances in the scaler chain.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 64, max cycles run may stay high before abort.

Ports:
- CLK_VIDEO  in  1  video clock; all logic on rising edge.
- RESET  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request level.
- req_op  in  NREQ  per-requester op: 0=mul, 1=div.
- req_a  in  NREQ*24  operand A, slice i = [24*i+23:24*i]. mul uses [11:0], div uses all 24 bits as numerator.
- req_b  in  NREQ*12  operand B: mul arg2 or div denominator.
- done  out  NREQ  one-cycle pulse to the owner when res is valid.
- err  out  1  qualifies done: divide-by-zero or timeout.
- res  out  24  result, held until the next done.
- busy  out  1  high from grant until done inclusive.
- mul_start  out  1  multiplier start pulse.
- mul_run  in  1  multiplier busy.
- mul_arg1, mul_arg2  out  12 each  multiplier operands.
- mul_res  in  24  multiplier result.
- div_start  out  1  divider start pulse.
- div_run  in  1  divider busy.
- div_num  out  24  divider numerator.
- div_den  out  12  divider denominator.
- div_res  in  24  divider result.

Behaviour:
- Reset (async): state IDLE, pointer=0, done=0, err=0, res=0, busy=0, mul_start=div_start=0, all operand outputs 0. Reset mid-operation abandons the op silently; no done is issued.
- FSM states: IDLE, ISSUE, WAIT1, WAIT, DONE.
- IDLE:
  - Scan req starting at pointer. The first set bit wins (owner).
  - Latch the owner's op and operands into the unit operand registers; busy<=1; go to ISSUE.
  - No req set: stay in IDLE.
- ISSUE:
  - mul: mul_start=1 for exactly one cycle.
  - div with den!=0: div_start=1 for exactly one cycle.
  - div with den==0: no start; res<=24'hFFFFFF, err<=1, go directly to DONE.
  - Otherwise go to WAIT1.
- WAIT1: one cycle that ignores run (the unit raises run the cycle after start). Go to WAIT and clear the timeout counter.
- WAIT:
  - Selected run==0: capture the selected unit result into res, err<=0, go to DONE.
  - Counter reaching TIMEOUT while run is still 1: res<=0, err<=1, go to DONE.
- DONE:
  - done[owner]=1 for one cycle; busy=0 after this cycle.
  - pointer<=(owner+1) mod NREQ; go to IDLE.
  - req is not sampled in DONE.
- Requester contract:
  - Hold req, req_op and operands stable from assertion until done.
  - Deassert req in the cycle done is seen. A req still high in the following IDLE cycle is a new request.
  - Operands are latched at grant, so later changes do not corrupt an op in flight.
- Latency: a req seen in IDLE at cycle 0 gives start at cycle 1 and done at cycle (run-high cycles + 3). With run high 3 cycles, done is at cycle 6.
- Simultaneous requests: round-robin. The last owner has lowest priority next time; no requester starves.
- Unused unit: its start stays 0 and its operands hold their last values.
- Only the selected unit's run is examined; the other unit's run is ignored.

Test Plan:
- Single mul: req[0]=1, op=0, a=400, b=2, unit model with run high 3 cycles -> mul_start pulse at cycle 1, done[0] at cycle 6, res=800, err=0.
- Single div: req[1]=1, op=1, a=3840, b=3 -> div_start pulse, done[1] with res=1280, err=0; mul_start never asserts.
- Fairness: req=2'b11 held continuously, each requester re-requesting on done -> grants alternate 0,1,0,1; each done carries its own result, e.g. 1080/400=2 and 512*2=1024.
- Divide by zero: op=1, b=0 -> no div_start, done 2 cycles after grant, res=24'hFFFFFF, err=1.
- Timeout: div_run stuck high -> done with err=1, res=0 after TIMEOUT+3 cycles; the next request is then served normally.
- Reset mid-op: assert RESET during WAIT -> done, busy and start go 0 immediately; after release, pointer=0 and a new req[1] completes correctly.
